// File: rtl/sd_host_phy_pkg.sv
// Shared types for the SD host PHY: SD clock FSM states and the DAT lane used for read-wait.
package sd_host_phy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        PAUSED = 2'd3
    } clk_state_t;

    localparam int READ_WAIT_LANE = 2;

endpackage

// File: rtl/sd_host_phy_clkgen.sv
// SD clock generator: divider FSM with rise/fall strobes one cycle ahead of the pin edge.
// Phases last clk_div+1 cycles; pause/disable only take effect at phase boundaries.
module sd_host_phy_clkgen
    import sd_host_phy_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pause,
    input  logic [DIV_WIDTH-1:0] clk_div,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic                 phy_clk
);

    clk_state_t           state, state_nxt;
    logic [DIV_WIDTH-1:0] count, count_nxt;
    // Holds the FSM and strobes quiet until the first clock after reset release.
    logic                 live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            phy_clk <= 1'b0;
            live    <= 1'b0;
        end else begin
            live    <= 1'b1;
            state   <= state_nxt;
            count   <= count_nxt;
            phy_clk <= (state_nxt == HIGH);
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rise_stb  = 1'b0;
        fall_stb  = 1'b0;
        if (live) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_nxt = HIGH;
                        count_nxt = clk_div;
                        rise_stb  = 1'b1;
                    end
                end
                HIGH: begin
                    if (count == '0) begin
                        state_nxt = LOW;
                        count_nxt = clk_div;
                        fall_stb  = 1'b1;
                    end else begin
                        count_nxt = count - DIV_WIDTH'(1);
                    end
                end
                LOW: begin
                    if (count == '0) begin
                        if (!enable) begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end else if (pause) begin
                            state_nxt = PAUSED;
                            count_nxt = '0;
                        end else begin
                            state_nxt = HIGH;
                            count_nxt = clk_div;
                            rise_stb  = 1'b1;
                        end
                    end else begin
                        count_nxt = count - DIV_WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (!pause) begin
                        state_nxt = HIGH;
                        count_nxt = clk_div;
                        rise_stb  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sd_host_phy_generic.sv
// Generic SD host PHY: fabric clock divider, TX launch on fall strobe, RX sync + selectable sample tap.
// RX valid lands 3+tap cycles after o_rise_stb. Optional read-wait on DAT2 via SD_PHY_READ_WAIT_EN.
module sd_host_phy_generic
    import sd_host_phy_pkg::*;
#(
    parameter int  DATA_WIDTH  = 4,
    parameter int  DIV_WIDTH   = 8,
    parameter int  SAMPLE_TAPS = 4,
    localparam int TAP_W       = $clog2(SAMPLE_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_pause,
    input  logic [DIV_WIDTH-1:0]  i_clk_div,
    input  logic [TAP_W-1:0]      i_sample_tap,
    output logic                  o_rise_stb,
    output logic                  o_fall_stb,
    input  logic                  i_sd_cmd_dir,
    input  logic                  i_sd_cmd_out,
    output logic                  o_sd_cmd_in,
    input  logic                  i_sd_data_dir,
    input  logic [DATA_WIDTH-1:0] i_sd_data_out,
    output logic [DATA_WIDTH-1:0] o_sd_data_in,
    output logic                  o_rx_vld,
    input  logic                  i_read_wait,
    output logic                  o_phy_clk,
    output logic                  o_phy_cmd_out,
    output logic                  o_phy_cmd_oe,
    input  logic                  i_phy_cmd,
    output logic [DATA_WIDTH-1:0] o_phy_data_out,
    output logic [DATA_WIDTH-1:0] o_phy_data_oe,
    input  logic [DATA_WIDTH-1:0] i_phy_data
);

    if (!(DATA_WIDTH == 1 || DATA_WIDTH == 4 || DATA_WIDTH == 8)) begin : g_bad_width
        $error("sd_host_phy_generic: DATA_WIDTH must be 1, 4 or 8");
    end
    if (SAMPLE_TAPS < 2 || (SAMPLE_TAPS & (SAMPLE_TAPS - 1)) != 0) begin : g_bad_taps
        $error("sd_host_phy_generic: SAMPLE_TAPS must be a power of two >= 2");
    end

    sd_host_phy_clkgen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (i_enable),
        .pause    (i_pause),
        .clk_div  (i_clk_div),
        .rise_stb (o_rise_stb),
        .fall_stb (o_fall_stb),
        .phy_clk  (o_phy_clk)
    );

    // TX launch registers: pins move in the same cycle the SD clock falls.
    logic                  cmd_dir_q, cmd_out_q, data_dir_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_dir_q  <= 1'b0;
            cmd_out_q  <= 1'b1;
            data_dir_q <= 1'b0;
            data_out_q <= '1;
        end else if (o_fall_stb) begin
            cmd_dir_q  <= i_sd_cmd_dir;
            cmd_out_q  <= i_sd_cmd_out;
            data_dir_q <= i_sd_data_dir;
            data_out_q <= i_sd_data_out;
        end
    end

    logic rw_drive;
`ifdef SD_PHY_READ_WAIT_EN
    if (DATA_WIDTH <= READ_WAIT_LANE) begin : g_rw_width
        $error("sd_host_phy_generic: read-wait needs DATA_WIDTH >= 4");
    end

    logic read_wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_wait_q <= 1'b0;
        end else if (o_fall_stb) begin
            read_wait_q <= i_read_wait;
        end
    end

    assign rw_drive = read_wait_q & ~data_dir_q;
`else
    logic unused_read_wait;
    assign unused_read_wait = i_read_wait;
    assign rw_drive         = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] rw_mask;
    if (DATA_WIDTH > READ_WAIT_LANE) begin : g_rw_mask
        always_comb begin
            rw_mask                 = '0;
            rw_mask[READ_WAIT_LANE] = rw_drive;
        end
    end else begin : g_no_rw_mask
        assign rw_mask = '0;
    end

    assign o_phy_cmd_oe   = cmd_dir_q;
    assign o_phy_cmd_out  = cmd_out_q;
    assign o_phy_data_oe  = {DATA_WIDTH{data_dir_q}} | rw_mask;
    assign o_phy_data_out = data_out_q & ~rw_mask;

    // RX: the tap delays the strobe, so a larger tap moves the effective sample point later
    // while the data itself always sits two flops behind the pins.
    logic [DATA_WIDTH:0]    rx_s1, rx_s2;
    logic                   stb_s1, stb_s2;
    logic [SAMPLE_TAPS-1:0] stb_taps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= '1;
            rx_s2    <= '1;
            stb_s1   <= 1'b0;
            stb_s2   <= 1'b0;
            stb_taps <= '0;
        end else begin
            rx_s1    <= {i_phy_cmd, i_phy_data};
            rx_s2    <= rx_s1;
            stb_s1   <= o_rise_stb;
            stb_s2   <= stb_s1;
            stb_taps <= {stb_taps[SAMPLE_TAPS-2:0], stb_s2};
        end
    end

    assign {o_sd_cmd_in, o_sd_data_in} = rx_s2;
    assign o_rx_vld                     = stb_taps[i_sample_tap];

endmodule

// File: tb/tb_sd_host_phy_generic.sv
// Scoreboard bench for sd_host_phy_generic: stimulus queues expected strobe/edge/RX/TX events, a monitor checks them.
module tb_sd_host_phy_generic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_enable, i_pause;
    logic [7:0] i_clk_div;
    logic [1:0] i_sample_tap;
    logic       o_rise_stb, o_fall_stb;
    logic       i_sd_cmd_dir, i_sd_cmd_out, o_sd_cmd_in;
    logic       i_sd_data_dir;
    logic [3:0] i_sd_data_out, o_sd_data_in;
    logic       o_rx_vld, i_read_wait;
    logic       o_phy_clk, o_phy_cmd_out, o_phy_cmd_oe, i_phy_cmd;
    logic [3:0] o_phy_data_out, o_phy_data_oe, i_phy_data;

    always #5 clk = ~clk;

    sd_host_phy_generic dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_pause        (i_pause),
        .i_clk_div      (i_clk_div),
        .i_sample_tap   (i_sample_tap),
        .o_rise_stb     (o_rise_stb),
        .o_fall_stb     (o_fall_stb),
        .i_sd_cmd_dir   (i_sd_cmd_dir),
        .i_sd_cmd_out   (i_sd_cmd_out),
        .o_sd_cmd_in    (o_sd_cmd_in),
        .i_sd_data_dir  (i_sd_data_dir),
        .i_sd_data_out  (i_sd_data_out),
        .o_sd_data_in   (o_sd_data_in),
        .o_rx_vld       (o_rx_vld),
        .i_read_wait    (i_read_wait),
        .o_phy_clk      (o_phy_clk),
        .o_phy_cmd_out  (o_phy_cmd_out),
        .o_phy_cmd_oe   (o_phy_cmd_oe),
        .i_phy_cmd      (i_phy_cmd),
        .o_phy_data_out (o_phy_data_out),
        .o_phy_data_oe  (o_phy_data_oe),
        .i_phy_data     (i_phy_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int         q_rise[$], q_fall[$], q_clkr[$], q_clkf[$], q_rx[$];
    logic [4:0] q_rxd[$];
    logic [9:0] q_tx[$];
    logic       clk_prev = 1'b0;

    // {cmd_oe, cmd_out, data_oe, data_out}
    localparam logic [9:0] TX_A = {1'b1, 1'b0, 4'hF, 4'hA};
`ifdef SD_PHY_READ_WAIT_EN
    localparam logic [9:0] TX_B = {1'b1, 1'b1, 4'h4, 4'h3};
`else
    localparam logic [9:0] TX_B = {1'b1, 1'b1, 4'h0, 4'h7};
`endif
    localparam logic [9:0] TX_C = {1'b1, 1'b0, 4'hF, 4'h6};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: samples away from the active edge and pops expectations on every DUT event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rise_stb) begin
                if (q_rise.size() == 0) unexpected("rise_stb");
                else check("rise_stb_cycle", cyc, q_rise.pop_front());
            end
            if (o_fall_stb) begin
                if (q_fall.size() == 0) unexpected("fall_stb");
                else check("fall_stb_cycle", cyc, q_fall.pop_front());
            end
            if (o_rx_vld) begin
                if (q_rx.size() == 0) unexpected("rx_vld");
                else begin
                    check("rx_vld_cycle", cyc, q_rx.pop_front());
                    check("rx_data", {o_sd_cmd_in, o_sd_data_in}, q_rxd.pop_front());
                end
            end
            if (o_phy_clk && !clk_prev) begin
                if (q_clkr.size() == 0) unexpected("phy_clk_rise");
                else check("phy_clk_rise_cycle", cyc, q_clkr.pop_front());
            end
            if (!o_phy_clk && clk_prev) begin
                if (q_clkf.size() == 0) unexpected("phy_clk_fall");
                else begin
                    check("phy_clk_fall_cycle", cyc, q_clkf.pop_front());
                    check("tx_pins", {o_phy_cmd_oe, o_phy_cmd_out, o_phy_data_oe, o_phy_data_out},
                          q_tx.pop_front());
                end
            end
        end
        clk_prev = o_phy_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, f, g;
        rst_n         = 1'b0;
        i_enable      = 1'b0;
        i_pause       = 1'b0;
        i_clk_div     = 8'd2;
        i_sample_tap  = 2'd0;
        i_sd_cmd_dir  = 1'b0;
        i_sd_cmd_out  = 1'b0;
        i_sd_data_dir = 1'b0;
        i_sd_data_out = 4'h0;
        i_read_wait   = 1'b0;
        i_phy_cmd     = 1'b0;
        i_phy_data    = 4'hC;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phy_clk",  o_phy_clk, 0);
        check("rst_cmd_oe",   o_phy_cmd_oe, 0);
        check("rst_data_oe",  o_phy_data_oe, 4'h0);
        check("rst_cmd_out",  o_phy_cmd_out, 1);
        check("rst_data_out", o_phy_data_out, 4'hF);
        check("rst_rx",       {o_sd_cmd_in, o_sd_data_in}, 5'h1F);
        check("rst_strobes",  {o_rise_stb, o_fall_stb, o_rx_vld}, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Divider 2: 3-high/3-low clock, tap 0, TX capture and hold.
        e = cyc + 4;
        for (int p = 0; p < 3; p++) begin
            q_rise.push_back(e + 6*p);
            q_clkr.push_back(e + 6*p + 1);
            q_fall.push_back(e + 6*p + 3);
            q_clkf.push_back(e + 6*p + 4);
            q_rx.push_back(e + 6*p + 3);
            q_rxd.push_back(5'h0C);
        end
        q_tx.push_back(TX_A);
        q_tx.push_back(TX_B);
        q_tx.push_back(TX_B);
        goto(e);
        i_enable      = 1'b1;
        i_sd_cmd_dir  = 1'b1;
        i_sd_data_dir = 1'b1;
        i_sd_cmd_out  = 1'b0;
        i_sd_data_out = 4'hA;
        goto(e + 5);
        i_sd_data_out = 4'h7;
        i_sd_cmd_out  = 1'b1;
        i_sd_data_dir = 1'b0;
        i_read_wait   = 1'b1;
        goto(e + 6);
        @(negedge clk);
        check("tx_hold_between_falls",
              {o_phy_cmd_oe, o_phy_cmd_out, o_phy_data_oe, o_phy_data_out}, TX_A);
        goto(e + 13);
        i_enable = 1'b0;

        // Divider 4, tap 3, pause across the LOW phase end.
        f = e + 24;
        q_rise.push_back(f);      q_rise.push_back(f + 14);
        q_clkr.push_back(f + 1);  q_clkr.push_back(f + 15);
        q_fall.push_back(f + 5);  q_fall.push_back(f + 19);
        q_clkf.push_back(f + 6);  q_clkf.push_back(f + 20);
        q_tx.push_back(TX_B);     q_tx.push_back(TX_B);
        q_rx.push_back(f + 6);    q_rx.push_back(f + 20);
        q_rxd.push_back(5'h15);   q_rxd.push_back(5'h15);
        goto(f);
        i_sample_tap = 2'd3;
        i_clk_div    = 8'd4;
        i_enable     = 1'b1;
        goto(f + 2);
        i_phy_cmd  = 1'b1;
        i_phy_data = 4'h5;
        i_pause    = 1'b1;
        goto(f + 14);
        i_pause = 1'b0;
        goto(f + 15);
        i_enable = 1'b0;

        // Divider 0: strobes alternate every cycle, then reset lands mid-HIGH.
        g = f + 30;
        goto(g - 2);
        i_sample_tap  = 2'd0;
        i_clk_div     = 8'd0;
        i_sd_cmd_dir  = 1'b1;
        i_sd_data_dir = 1'b1;
        i_sd_cmd_out  = 1'b0;
        i_sd_data_out = 4'h6;
        i_read_wait   = 1'b0;
        for (int k = 0; k < 4; k++) q_rise.push_back(g + 2*k);
        for (int k = 0; k < 3; k++) begin
            q_fall.push_back(g + 2*k + 1);
            q_clkr.push_back(g + 2*k + 1);
            q_clkf.push_back(g + 2*k + 2);
            q_tx.push_back(TX_C);
        end
        q_rx.push_back(g + 3);  q_rxd.push_back(5'h15);
        q_rx.push_back(g + 5);  q_rxd.push_back(5'h15);
        goto(g);
        i_enable = 1'b1;
        goto(g + 7);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_phy_clk",  o_phy_clk, 0);
        check("midrst_oes",      {o_phy_cmd_oe, o_phy_data_oe}, 5'h00);
        check("midrst_pins",     {o_phy_cmd_out, o_phy_data_out}, 5'h1F);
        check("midrst_strobes",  {o_rise_stb, o_fall_stb, o_rx_vld}, 3'b000);
        check("midrst_rx",       {o_sd_cmd_in, o_sd_data_in}, 5'h1F);
        repeat (2) @(posedge clk);
        #1;
        check("queues_drained",
              q_rise.size() + q_fall.size() + q_clkr.size() + q_clkf.size() + q_rx.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
